uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Merges two byte streams into the single host-bound UART/USB input pipeline: keyboard keystrokes and terminal-generated reply packets (e.g. the ESC Z identify reply `ESC / K`, 0x1B 0x2F 0x4B). Multi-byte packets are granted atomically so escape sequences never interleave. Ties between packets are broken by round-robin arbitration, and a burst limit prevents either source from starving the other. Sits in the clk_usb domain between keyboard/command_handler and the usb_uart (or ALT_UART) `uart_in_*` port.

## Interface

- MAX_BURST, 16: maximum bytes in one granted packet before the lock is forcibly released (2..255).

- clk  in  1  system clock (clk_usb, 48 MHz)
- reset  in  1  asynchronous, active-high reset
- kbd_data  in  8  keyboard byte
- kbd_valid  in  1  keyboard byte available
- kbd_last  in  1  byte is last of keyboard packet (tie high for single-byte keys)
- kbd_ready  out  1  keyboard byte accepted this cycle when kbd_valid&kbd_ready
- resp_data  in  8  reply byte from command_handler
- resp_valid  in  1  reply byte available
- resp_last  in  1  byte is last of reply packet
- resp_ready  out  1  reply byte accepted
- out_data  out  8  byte to uart_in_data
- out_valid  out  1  to uart_in_valid
- out_ready  in  1  from uart_in_ready
- busy  out  1  lock held (state != IDLE)
- overlong  out  1  sticky: a packet hit MAX_BURST without last; cleared only by reset

## Operation

- States: IDLE, LOCK_KBD, LOCK_RESP.
- IDLE: kbd_ready=resp_ready=0. If exactly one source is valid, go to its LOCK state. If both are valid, grant the source not granted last (last_grant register); after reset last_grant=KBD, so RESP wins the first tie. Update last_grant on entry to a LOCK state. No request: stay.
- LOCK_x: x_ready = !out_valid | out_ready; the other source's ready = 0. On each accepted byte (x_valid & x_ready): load out_data, set out_valid, burst_cnt += 1.
  - Accepted byte with x_last=1: return to IDLE, burst_cnt=0.
  - Accepted byte with burst_cnt reaching MAX_BURST and x_last=0: set overlong, return to IDLE, burst_cnt=0. The remainder of the packet re-arbitrates as a new request.
- Output register: out_valid clears when out_ready & out_valid and no new byte loads the same cycle. out_data is held stable while out_valid & !out_ready.
- burst_cnt is 8 bits. Compare with == MAX_BURST. It never wraps because it is reset on release.
- Valid deasserted mid-packet while locked: hold the lock and wait; no timeout.
- Reset mid-operation: the byte in the output register is discarded. All state returns to reset values.

## Timing

- Reset values: out_valid=0, out_data=0x00, kbd_ready=0, resp_ready=0, busy=0, overlong=0, state=IDLE, burst_cnt=0, last_grant=KBD.
- Arbitration: 1 cycle. The request is seen in IDLE at cycle N; ready is first possible at N+1.
- Latency: a byte accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1).
- Throughput within a packet: 1 byte/cycle while out_ready=1. There is 1 idle cycle between packets (the IDLE state).
- x_ready is combinational from state, out_valid and out_ready. Every other output is registered.
- Simultaneous out_ready handshake and new-byte load in the same cycle: out_valid stays 1 and out_data updates.

## Test plan

- Single key: kbd_data=0x41, kbd_last=1, out_ready=1 -> kbd_ready at cycle 1, out_data=0x41 with out_valid for 1 cycle at cycle 2, busy back to 0.
- Both valid at cycle 0 after reset: resp packet 0x1B,0x2F,0x4B (last on 0x4B) and kbd 0x61 -> out sequence 0x1B,0x2F,0x4B,0x61, with no keyboard byte inside the reply. A second simultaneous tie then grants KBD first.
- Backpressure: out_ready=0 for 5 cycles mid-reply -> out_data holds 0x2F, resp_ready=0, no byte is lost or duplicated after release.
- Overlong: MAX_BURST=4, kbd sends 6 bytes with last only on the 6th while resp has a pending 0x1B (last=1) -> out 4 kbd bytes, then 0x1B, then the remaining 2 kbd bytes; overlong=1 and stays 1.
- Reset asserted while out_valid=1 with a packet half sent -> out_valid=0, busy=0, overlong=0 immediately (asynchronous). After release, a new packet transfers normally.
- Continuous keyboard stream of single-byte packets with resp idle -> 1 byte every 2 cycles. Asserting resp_valid is granted at the next IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Merges keyboard bytes and terminal reply packets into one UART input stream.
// Packets are granted atomically, ties alternate round-robin, and MAX_BURST bounds each grant.
module uart_tx_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_kbd_data,
    input  logic       i_kbd_valid,
    input  logic       i_kbd_last,
    output logic       o_kbd_ready,
    input  logic [7:0] i_resp_data,
    input  logic       i_resp_valid,
    input  logic       i_resp_last,
    output logic       o_resp_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_busy,
    output logic       o_overlong
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_KBD  = 2'd1,
        LOCK_RESP = 2'd2
    } state_t;

    localparam logic [7:0] MAX_BURST_8 = 8'(MAX_BURST);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_last_grant_resp;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_overlong;

    logic       w_take;
    logic       w_sel_valid;
    logic       w_sel_last;
    logic [7:0] w_sel_data;
    logic       w_accept;
    logic [7:0] w_cnt_inc;
    logic       w_burst_hit;
    logic       w_release;

    // The output register can take a byte when empty or when it drains this cycle.
    assign w_take       = !r_out_valid || i_out_ready;
    assign o_kbd_ready  = (r_state == LOCK_KBD)  && w_take;
    assign o_resp_ready = (r_state == LOCK_RESP) && w_take;

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        case (r_state)
            LOCK_KBD: begin
                w_sel_valid = i_kbd_valid;
                w_sel_last  = i_kbd_last;
                w_sel_data  = i_kbd_data;
            end
            LOCK_RESP: begin
                w_sel_valid = i_resp_valid;
                w_sel_last  = i_resp_last;
                w_sel_data  = i_resp_data;
            end
            default: ;
        endcase
    end

    assign w_accept    = w_sel_valid && w_take;
    assign w_cnt_inc   = r_burst_cnt + 8'd1;
    assign w_burst_hit = (w_cnt_inc == MAX_BURST_8);
    assign w_release   = w_accept && (w_sel_last || w_burst_hit);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_kbd_valid && i_resp_valid) begin
                    w_next_state = r_last_grant_resp ? LOCK_KBD : LOCK_RESP;
                end else if (i_kbd_valid) begin
                    w_next_state = LOCK_KBD;
                end else if (i_resp_valid) begin
                    w_next_state = LOCK_RESP;
                end
            end
            LOCK_KBD, LOCK_RESP: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant_resp <= 1'b0;
            r_burst_cnt       <= 8'h00;
            r_out_data        <= 8'h00;
            r_out_valid       <= 1'b0;
            r_overlong        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_sel_data;
                r_out_valid <= 1'b1;
                r_burst_cnt <= w_release ? 8'h00 : w_cnt_inc;
                if (w_burst_hit && !w_sel_last) begin
                    r_overlong <= 1'b1;
                end
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if ((r_state == IDLE) && (w_next_state != IDLE)) begin
                r_last_grant_resp <= (w_next_state == LOCK_RESP);
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_overlong  = r_overlong;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter (MAX_BURST=4) against a chunk-level
// round-robin model of the merged output stream.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int MAX_B  = 4;
    localparam int BUDGET = 300;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic       clk;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_last;
    logic       kbd_ready;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_last;
    logic       resp_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overlong;

    int n_checks = 0;
    int n_fail   = 0;

    byte_t      kpk[$];
    byte_t      rpk[$];
    byte_t      kbd_q[$];
    byte_t      resp_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    bit         exp_lg_kbd;
    bit         exp_ovl;
    bit         drv_done;
    bit         mon_stop;

    uart_tx_arbiter #(.MAX_BURST(MAX_B)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_kbd_data   (kbd_data),
        .i_kbd_valid  (kbd_valid),
        .i_kbd_last   (kbd_last),
        .o_kbd_ready  (kbd_ready),
        .i_resp_data  (resp_data),
        .i_resp_valid (resp_valid),
        .i_resp_last  (resp_last),
        .o_resp_ready (resp_ready),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_busy       (busy),
        .o_overlong   (overlong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_streams();
        kpk.delete(); rpk.delete(); kbd_q.delete(); resp_q.delete();
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic add_byte(input bit is_resp, input logic [7:0] d, input logic l);
        byte_t b;
        b.d = d;
        b.l = l;
        if (is_resp) begin
            rpk.push_back(b); resp_q.push_back(b);
        end else begin
            kpk.push_back(b); kbd_q.push_back(b);
        end
    endtask

    task automatic gen_packets(input bit is_resp, input int npk);
        for (int p = 0; p < npk; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                add_byte(is_resp, 8'($urandom_range(0, 255)), (i == len - 1));
            end
        end
    endtask

    // Reference: sources are split into grants of at most MAX_B bytes (or up to a last byte);
    // while both have grants pending they alternate, starting away from the last granted source.
    task automatic model_expect();
        int ki;
        int ri;
        ki = 0;
        ri = 0;
        exp_q.delete();
        while (ki < kpk.size() || ri < rpk.size()) begin
            bit take_resp;
            int n;
            bit done;
            byte_t b;
            if (ki >= kpk.size())      take_resp = 1'b1;
            else if (ri >= rpk.size()) take_resp = 1'b0;
            else                       take_resp = exp_lg_kbd;
            n = 0;
            done = 1'b0;
            while (!done) begin
                if (take_resp) begin b = rpk[ri]; ri++; end
                else begin b = kpk[ki]; ki++; end
                exp_q.push_back(b.d);
                n++;
                if (b.l) done = 1'b1;
                else if (n == MAX_B) begin done = 1'b1; exp_ovl = 1'b1; end
            end
            exp_lg_kbd = !take_resp;
        end
    endtask

    task automatic set_src(input bit is_resp, input logic v, input byte_t b);
        if (is_resp) begin
            resp_valid = v; resp_data = b.d; resp_last = b.l;
        end else begin
            kbd_valid = v; kbd_data = b.d; kbd_last = b.l;
        end
    endtask

    task automatic apply_reset();
        kbd_valid = 0; kbd_data = 0; kbd_last = 0;
        resp_valid = 0; resp_data = 0; resp_last = 0;
        out_ready = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        exp_lg_kbd = 1'b1;
        exp_ovl = 1'b0;
    endtask

    task automatic src_driver(input bit is_resp, input int delay, input int gap_pct);
        int pos;
        int waited;
        bit acc;
        byte_t b;
        pos = 0;
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        while ((is_resp ? resp_q.size() : kbd_q.size()) > 0) begin
            b = is_resp ? resp_q[0] : kbd_q[0];
            if (pos != 0 && $urandom_range(0, 99) < gap_pct) begin
                set_src(is_resp, 1'b0, b);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            set_src(is_resp, 1'b1, b);
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < BUDGET) begin
                @(negedge clk);
                acc = is_resp ? resp_ready : kbd_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            n_checks++;
            if (!acc) begin
                n_fail++;
                $display("FAIL %s_handshake: ready got 0 for %0d cycles, required 1", is_resp ? "resp" : "kbd", BUDGET);
                if (is_resp) resp_q.delete(); else kbd_q.delete();
                break;
            end
            if (is_resp) void'(resp_q.pop_front()); else void'(kbd_q.pop_front());
            pos = (b.l || pos + 1 == MAX_B) ? 0 : pos + 1;
        end
        set_src(is_resp, 1'b0, '0);
    endtask

    task automatic monitor_loop();
        bit hold;
        logic [7:0] held;
        int cyc;
        hold = 1'b0;
        held = 8'h00;
        cyc = 0;
        while (!mon_stop) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b data=%02h, required valid=1 data=%02h", out_valid, out_data, held);
                end
            end
            n_checks++;
            if (kbd_ready === 1'b1 && resp_ready === 1'b1) begin
                n_fail++;
                $display("FAIL ready_exclusive: got kbd_ready=1 resp_ready=1, required at most one");
            end
            if (out_valid === 1'b1 && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            hold = (out_valid === 1'b1) && !out_ready;
            held = out_data;
        end
    endtask

    task automatic ready_gen(input int pct);
        while (!drv_done) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < pct);
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon_stop = 1'b1;
    endtask

    task automatic run_traffic(input int rdy_pct, input int kdelay, input int rdelay, input int gap_pct);
        got_q.delete();
        got_cyc.delete();
        drv_done = 1'b0;
        mon_stop = 1'b0;
        fork
            begin
                fork
                    src_driver(1'b0, kdelay, gap_pct);
                    src_driver(1'b1, rdelay, gap_pct);
                join
                drv_done = 1'b1;
            end
            ready_gen(rdy_pct);
            monitor_loop();
        join
    endtask

    task automatic compare_stream(input string name);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_length: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_kbd_ready", kbd_ready, 1'b0);
        check_bit("reset_resp_ready", resp_ready, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_overlong", overlong, 1'b0);
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_data: got %02h, required 00", out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_key();
        apply_reset();
        out_ready = 1'b1;
        kbd_valid = 1'b1; kbd_data = 8'h41; kbd_last = 1'b1;
        @(negedge clk);
        check_bit("key_c0_ready", kbd_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("key_c1_ready", kbd_ready, 1'b1);
        check_bit("key_c1_busy", busy, 1'b1);
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        @(negedge clk);
        check_bit("key_c2_valid", out_valid, 1'b1);
        check_bit("key_c2_busy", busy, 1'b0);
        n_checks++;
        if (out_data !== 8'h41) begin
            n_fail++;
            $display("FAIL key_c2_data: got %02h, required 41", out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("key_c3_valid", out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        apply_reset();
        clear_streams();
        add_byte(1'b1, 8'h1B, 1'b0); add_byte(1'b1, 8'h2F, 1'b0); add_byte(1'b1, 8'h4B, 1'b1);
        add_byte(1'b1, 8'h1B, 1'b0); add_byte(1'b1, 8'h5A, 1'b1);
        add_byte(1'b0, 8'h61, 1'b1);
        exp_q = '{8'h1B, 8'h2F, 8'h4B, 8'h61, 8'h1B, 8'h5A};
        run_traffic(100, 0, 0, 0);
        compare_stream("tie");
    endtask

    task automatic test_backpressure();
        bit found;
        apply_reset();
        clear_streams();
        add_byte(1'b1, 8'h1B, 1'b0); add_byte(1'b1, 8'h2F, 1'b0); add_byte(1'b1, 8'h4B, 1'b1);
        exp_q = '{8'h1B, 8'h2F, 8'h4B};
        out_ready = 1'b1;
        mon_stop = 1'b0;
        got_q.delete();
        got_cyc.delete();
        fork
            src_driver(1'b1, 0, 0);
            monitor_loop();
            begin
                found = 1'b0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    found = (out_valid === 1'b1 && out_data === 8'h1B);
                end
                n_checks++;
                if (!found) begin
                    n_fail++;
                    $display("FAIL bp_first_byte: got no 1B within 20 cycles, required 1B");
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_bit("bp_resp_ready", resp_ready, 1'b0);
                    check_bit("bp_out_valid", out_valid, 1'b1);
                    n_checks++;
                    if (out_data !== 8'h2F) begin
                        n_fail++;
                        $display("FAIL bp_hold_data: got %02h, required 2F", out_data);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                mon_stop = 1'b1;
            end
        join
        compare_stream("backpressure");
    endtask

    task automatic test_overlong();
        apply_reset();
        clear_streams();
        for (int i = 0; i < 6; i++) add_byte(1'b0, 8'hA0 + 8'(i), (i == 5));
        add_byte(1'b1, 8'h1B, 1'b1);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h1B, 8'hA4, 8'hA5};
        run_traffic(100, 0, 2, 0);
        compare_stream("overlong");
        check_bit("overlong_set", overlong, 1'b1);
        clear_streams();
        add_byte(1'b0, 8'h31, 1'b0); add_byte(1'b0, 8'h32, 1'b1);
        exp_q = '{8'h31, 8'h32};
        run_traffic(100, 0, 0, 0);
        compare_stream("after_overlong");
        check_bit("overlong_sticky", overlong, 1'b1);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        resp_valid = 1'b1; resp_data = 8'h1B; resp_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resp_data = 8'h2F;
        #2;
        check_bit("mid_pre_valid", out_valid, 1'b1);
        check_bit("mid_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("mid_out_valid", out_valid, 1'b0);
        check_bit("mid_busy", busy, 1'b0);
        check_bit("mid_overlong", overlong, 1'b0);
        check_bit("mid_resp_ready", resp_ready, 1'b0);
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_out_data: got %02h, required 00", out_data);
        end
        resp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_lg_kbd = 1'b1;
        exp_ovl = 1'b0;
        clear_streams();
        gen_packets(1'b0, 1);
        gen_packets(1'b1, 1);
        model_expect();
        run_traffic(100, 0, 0, 0);
        compare_stream("post_reset");
        check_bit("post_reset_overlong", overlong, exp_ovl);
    endtask

    task automatic test_stream();
        logic [7:0] kb[6];
        apply_reset();
        clear_streams();
        for (int i = 0; i < 6; i++) begin
            kb[i] = 8'($urandom_range(0, 255));
            add_byte(1'b0, kb[i], 1'b1);
        end
        add_byte(1'b1, 8'h1B, 1'b1);
        exp_q = '{kb[0], kb[1], 8'h1B, kb[2], kb[3], kb[4], kb[5]};
        run_traffic(100, 0, 3, 0);
        compare_stream("stream");
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_checks++;
            if (got_cyc[i] - got_cyc[i-1] != 2) begin
                n_fail++;
                $display("FAIL stream_spacing%0d: got %0d cycles, required 2", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            clear_streams();
            gen_packets(1'b0, $urandom_range(2, 5));
            gen_packets(1'b1, $urandom_range(2, 5));
            model_expect();
            run_traffic($urandom_range(50, 100), 0, 0, 25);
            compare_stream("random");
            check_bit("random_overlong", overlong, exp_ovl);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_tie();
        test_backpressure();
        test_overlong();
        test_reset_mid();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
